// File: rtl/jk_down_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | jk_down_counter: loadable down counter, IDLE/RUN/DONE FSM, one-cycle tc    |
// | Optional: JK_DOWN_CNT_RELOAD_EN enables auto-reload at terminal count.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module jk_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             t,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q1,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] q_nx;
  logic             tc_nx;

`ifdef JK_DOWN_CNT_RELOAD_EN
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nx;
`endif

  always_comb begin
    state_nx  = state;
    q_nx      = q;
    tc_nx     = 1'b0;
`ifdef JK_DOWN_CNT_RELOAD_EN
    reload_nx = reload;
`endif
    if (load) begin
      q_nx     = din;
      state_nx = (din != '0) ? RUN : DONE;
`ifdef JK_DOWN_CNT_RELOAD_EN
      reload_nx = din;
`endif
    end else begin
      case (state)
        RUN: begin
          if (t) begin
            if (q > ONE) begin
              q_nx = q - ONE;
            end else if (q == ONE) begin
              tc_nx = 1'b1;
`ifdef JK_DOWN_CNT_RELOAD_EN
              q_nx  = reload;
`else
              q_nx     = '0;
              state_nx = DONE;
`endif
            end else begin
              // q==0 cannot occur in RUN; park in DONE rather than wrap
              state_nx = DONE;
            end
          end
        end
        IDLE, DONE: begin
          state_nx = state;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q     <= '0;
      q1    <= '1;
      tc    <= 1'b0;
`ifdef JK_DOWN_CNT_RELOAD_EN
      reload <= '0;
`endif
    end else begin
      state <= state_nx;
      q     <= q_nx;
      q1    <= ~q_nx;
      tc    <= tc_nx;
`ifdef JK_DOWN_CNT_RELOAD_EN
      reload <= reload_nx;
`endif
    end
  end

  assign busy = (state == RUN);

endmodule
`default_nettype wire
